// File: rtl/rhs_mem_datapath_param.sv
// Parametrised memory datapath: lane-masked write port, NRD read ports, init sweep FSM,
// dynamic slice on read port 0 feeding a wrapping accumulator.
module rhs_mem_datapath_param #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned LANE_W      = 8,
    parameter int unsigned NRD         = 2,
    parameter int unsigned READ_LAT    = 1,
    parameter int unsigned WRITE_FIRST = 1,
    parameter int unsigned SLICE_W     = 8,
    parameter int unsigned ACC_W       = 12,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned NL    = WIDTH / LANE_W,
    localparam int unsigned OFF_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [NL-1:0]        wr_mask,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    input  logic [OFF_W-1:0]     slice_off,
    output logic [SLICE_W-1:0]   slice_res,
    input  logic                 acc_en,
    output logic [ACC_W-1:0]     acc,
    output logic                 init_busy
);

    localparam int unsigned EXT_W  = WIDTH + SLICE_W;
    localparam int unsigned EXT_AW = $clog2(EXT_W);

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic               init_busy_q, init_busy_d;
    logic [ACC_W-1:0]   acc_q, acc_d;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               wr_active;
    logic [WIDTH-1:0]   wr_merged;
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [WIDTH-1:0]   mem_wdata;
    logic [NRD*WIDTH-1:0] rd_d;
    logic [EXT_W-1:0]   slice_ext;

    // Sweep FSM: one word per cycle, clr restarts from address 0
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                if (clr) begin
                    ptr_d = '0;
                end else if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
        init_busy_d = (state_d == ST_INIT);
    end

    // Accumulator: clr wins over acc_en, and acc holds during the sweep
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en && !init_busy_q) begin
            acc_d = acc_q + ACC_W'(slice_res);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            init_busy_q <= 1'b1;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_busy_q <= init_busy_d;
            acc_q       <= acc_d;
        end
    end

    assign wr_active = !init_busy_q && wr_en && (|wr_mask);

    // Lane merge of new data over the currently stored word
    always_comb begin
        wr_merged = mem_q[wr_addr];
        for (int i = 0; i < NL; i++) begin
            if (wr_mask[i]) begin
                wr_merged[i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        mem_we    = init_busy_q || wr_active;
        mem_waddr = init_busy_q ? ptr_q : wr_addr;
        mem_wdata = init_busy_q ? INIT_VAL : wr_merged;
    end

    // Storage array is deliberately left without reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read ports collide independently with the active write
    always_comb begin
        rd_d = '0;
        for (int p = 0; p < NRD; p++) begin
            logic [AW-1:0]    ra;
            logic [WIDTH-1:0] word;
            ra   = rd_addr[p*AW +: AW];
            word = mem_q[ra];
            if ((WRITE_FIRST != 0) && wr_active && (ra == wr_addr)) begin
                word = wr_merged;
            end
            if (!init_busy_q) begin
                rd_d[p*WIDTH +: WIDTH] = word;
            end
        end
    end

    if (READ_LAT == 0) begin : g_rd_comb
        assign rd_data = rd_d;
    end else begin : g_rd_reg
        logic [NRD*WIDTH-1:0] rd_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end
        assign rd_data = rd_q;
    end

    // Zero-extension makes slice bits beyond WIDTH read as 0
    assign slice_ext = EXT_W'(rd_data[WIDTH-1:0]);
    assign slice_res = slice_ext[EXT_AW'(slice_off) +: SLICE_W];

    assign acc       = acc_q;
    assign init_busy = init_busy_q;

endmodule

// File: tb/tb_rhs_mem_datapath_param.sv
// Directed bench: default build, a read-first build and a combinational-read build share stimulus.
module tb_rhs_mem_datapath_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [1:0]  wr_mask;
    logic [15:0] wr_data;
    logic [3:0]  rd_addr;
    logic [3:0]  slice_off;
    logic        acc_en;

    logic [31:0] rd_m, rd_r, rd_c;
    logic [7:0]  sl_m, sl_r, sl_c;
    logic [11:0] acc_m, acc_r, acc_c;
    logic        busy_m, busy_r, busy_c;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    rhs_mem_datapath_param u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_m),
        .slice_off(slice_off), .slice_res(sl_m), .acc_en(acc_en), .acc(acc_m),
        .init_busy(busy_m)
    );

    rhs_mem_datapath_param #(.WRITE_FIRST(0)) u_rf (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_r),
        .slice_off(slice_off), .slice_res(sl_r), .acc_en(acc_en), .acc(acc_r),
        .init_busy(busy_r)
    );

    rhs_mem_datapath_param #(.READ_LAT(0)) u_comb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_c),
        .slice_off(slice_off), .slice_res(sl_c), .acc_en(acc_en), .acc(acc_c),
        .init_busy(busy_c)
    );

    typedef struct {
        logic        we;
        logic [1:0]  wa;
        logic [1:0]  wm;
        logic [15:0] wd;
        logic [1:0]  ra0;
        logic [1:0]  ra1;
        logic [3:0]  so;
        logic [15:0] e0;   // write-first expectation, port 0
        logic [15:0] e1;
        logic [15:0] f0;   // read-first expectation, port 0
        logic [15:0] f1;
        logic [7:0]  es;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Counts edges until init_busy drops, bounded
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy_m && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    initial begin
        //            we    wa    wm     wd        ra0   ra1   so     e0        e1        f0        f1        es
        vecs[0] = '{1'b1, 2'd1, 2'b11, 16'hBEEF, 2'd1, 2'd1, 4'd0,  16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000, 8'hEF};
        vecs[1] = '{1'b1, 2'd1, 2'b01, 16'h1234, 2'd1, 2'd0, 4'd4,  16'hBE34, 16'h0000, 16'hBEEF, 16'h0000, 8'hE3};
        vecs[2] = '{1'b0, 2'd0, 2'b00, 16'h0000, 2'd1, 2'd1, 4'd8,  16'hBE34, 16'hBE34, 16'hBE34, 16'hBE34, 8'hBE};
        vecs[3] = '{1'b1, 2'd2, 2'b11, 16'hCAFE, 2'd2, 2'd2, 4'd12, 16'hCAFE, 16'hCAFE, 16'h0000, 16'h0000, 8'h0C};
        vecs[4] = '{1'b1, 2'd0, 2'b11, 16'hA5F0, 2'd2, 2'd1, 4'd4,  16'hCAFE, 16'hBE34, 16'hCAFE, 16'hBE34, 8'hAF};
        vecs[5] = '{1'b1, 2'd0, 2'b00, 16'hFFFF, 2'd0, 2'd2, 4'd4,  16'hA5F0, 16'hCAFE, 16'hA5F0, 16'hCAFE, 8'h5F};
        vecs[6] = '{1'b0, 2'd0, 2'b00, 16'h0000, 2'd0, 2'd2, 4'd12, 16'hA5F0, 16'hCAFE, 16'hA5F0, 16'hCAFE, 8'h0A};
        vecs[7] = '{1'b1, 2'd2, 2'b10, 16'h1111, 2'd2, 2'd3, 4'd9,  16'h11FE, 16'h0000, 16'hCAFE, 16'h0000, 8'h08};
        vecs[8] = '{1'b0, 2'd0, 2'b00, 16'h0000, 2'd3, 2'd0, 4'd0,  16'h0000, 16'hA5F0, 16'h0000, 16'hA5F0, 8'h00};

        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        rd_addr = '0; slice_off = '0; acc_en = 1'b0;

        // Reset state, then sweep length with writes attempted while busy
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy_m), 32'd1);
        check("reset_rd", rd_m, 32'h0);
        check("reset_acc", 32'(acc_m), 32'h0);
        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd0; wr_mask = 2'b11; wr_data = 16'hFFFF;
        count_busy(n);
        check("init_sweep_cycles", 32'(n), 32'd4);
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk); #1;
        check("busy_write_lost", rd_m, 32'h0);

        // Table-driven read/write/collision/slice vectors
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_mask = vecs[i].wm; wr_data = vecs[i].wd;
            rd_addr = {vecs[i].ra1, vecs[i].ra0}; slice_off = vecs[i].so;
            #1;
            check($sformatf("v%0d_comb_rd0", i), 32'(rd_c[15:0]),  32'(vecs[i].e0));
            check($sformatf("v%0d_comb_rd1", i), 32'(rd_c[31:16]), 32'(vecs[i].e1));
            check($sformatf("v%0d_comb_slice", i), 32'(sl_c), 32'(vecs[i].es));
            @(posedge clk); #1;
            check($sformatf("v%0d_wf_rd0", i), 32'(rd_m[15:0]),  32'(vecs[i].e0));
            check($sformatf("v%0d_wf_rd1", i), 32'(rd_m[31:16]), 32'(vecs[i].e1));
            check($sformatf("v%0d_wf_slice", i), 32'(sl_m), 32'(vecs[i].es));
            check($sformatf("v%0d_rf_rd0", i), 32'(rd_r[15:0]),  32'(vecs[i].f0));
            check($sformatf("v%0d_rf_rd1", i), 32'(rd_r[31:16]), 32'(vecs[i].f1));
        end

        // Accumulator wrap: 17 x 0xFF = 4335 -> 0x0EF mod 4096
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'd3; wr_mask = 2'b11; wr_data = 16'h00FF;
        rd_addr = {2'd0, 2'd3}; slice_off = 4'd0;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        check("acc_before", 32'(acc_m), 32'h0);
        check("slice_ff", 32'(sl_m), 32'hFF);
        acc_en = 1'b1;
        repeat (17) @(posedge clk);
        @(negedge clk);
        acc_en = 1'b0;
        check("acc_wrap_wf", 32'(acc_m), 32'h0EF);
        check("acc_wrap_rf", 32'(acc_r), 32'h0EF);
        check("acc_wrap_comb", 32'(acc_c), 32'h0EF);

        // clr together with acc_en: clear wins, sweep re-runs
        clr = 1'b1; acc_en = 1'b1;
        @(posedge clk); #1;
        check("clr_acc", 32'(acc_m), 32'h0);
        check("clr_busy", 32'(busy_m), 32'd1);
        @(negedge clk);
        clr = 1'b0; acc_en = 1'b0;
        count_busy(n);
        check("clr_sweep_cycles", 32'(n - 1 + 1), 32'd4);
        @(negedge clk);
        rd_addr = {2'd2, 2'd3};
        @(posedge clk); #1;
        check("clr_cleared_rd", rd_m, 32'h0);

        // Reset aborts mid-sweep and restarts from address 0
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'd3; wr_mask = 2'b11; wr_data = 16'h00FF;
        rd_addr = {2'd0, 2'd3};
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        acc_en = 1'b1;
        @(negedge clk);
        acc_en = 1'b0;
        check("pre_reset_acc", 32'(acc_m), 32'h0FF);
        rst_n = 1'b0;
        #1;
        check("rst_acc", 32'(acc_m), 32'h0);
        check("rst_rd", rd_m, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy_m), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        check("rst_mid_sweep_cycles", 32'(n), 32'd4);
        check("rst_mid_acc", 32'(acc_m), 32'h0);
        @(posedge clk); #1;
        check("rst_mid_rd", rd_m, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
